target_locator: RTL and testbench
=================================

// Module: target_locator
// PURPOSE
//  Consumes the per-pixel colour flags produced by the colour-threshold stage and the camera pixel strobes.
//  Accumulates, per frame, the pixel count and bounding box of one selected target colour.
//  At end of frame reports found/not-found, bbox and centre (x,y) to the robot steering/UART logic.
// PARAMETERS
//  IMG_W      320  active pixels per line
//  IMG_H      240  active lines per frame
//  MIN_PIX    64   minimum matching pixels for target_found=1
//  DEADBAND   16   half-width (px) of centre zone; used only with TARGET_DIRECTION_EN
// PORTS
//  clk           in   1   pixel clock
//  rst           in   1   asynchronous reset, active-high
//  pix_valid     in   1   pixel/flags valid this cycle
//  sof           in   1   first pixel of frame; qualified by pix_valid
//  eol           in   1   last pixel of line; qualified by pix_valid
//  is_orange     in   1   colour flag, qualified by pix_valid
//  is_pink       in   1   colour flag, qualified by pix_valid
//  is_purple     in   1   colour flag, qualified by pix_valid
//  is_blue       in   1   colour flag, qualified by pix_valid
//  is_green      in   1   colour flag, qualified by pix_valid
//  target_sel    in   3   0 orange, 1 pink, 2 purple, 3 blue, 4 green; 5-7 match nothing
//  busy          out  1   high while a frame is being accumulated
//  result_valid  out  1   one-cycle pulse: results below updated
//  target_found  out  1   count >= MIN_PIX
//  target_x      out  XW  (min_x+max_x)>>1; XW=$clog2(IMG_W)
//  target_y      out  YW  (min_y+max_y)>>1; YW=$clog2(IMG_H)
//  bbox_min_x    out  XW  bounding box left edge
//  bbox_max_x    out  XW  bounding box right edge
//  bbox_min_y    out  YW  bounding box top edge
//  bbox_max_y    out  YW  bounding box bottom edge
//  pixel_count   out  CW  matching pixels, CW=$clog2(IMG_W*IMG_H+1)
//  frame_err     out  1   one-cycle pulse: frame aborted
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; x/y counters 0; accumulators cleared.
//  FSM: IDLE -> ACCUM on pix_valid&sof. ACCUM -> REPORT on pix_valid&eol with y==IMG_H-1. REPORT -> IDLE after 1 cycle.
//  IDLE: pixels without sof are ignored.
//  On sof:
//   - x=0, y=0.
//   - target_sel is latched; changes mid-frame take effect next frame.
//   - Accumulators are cleared; the sof pixel itself is counted.
//  Counters: x++ per valid pixel, saturating at IMG_W-1. Valid eol sets x=0, y++ (saturating at IMG_H-1).
//  Match = pix_valid & selected flag. On match:
//   - count++ (saturating).
//   - min/max x,y updated against the current (x,y); first match loads both min and max.
//  Latency: result_valid asserted in REPORT, the cycle after the final eol pixel. Final-pixel match is included.
//  Results are registered and held until the next result_valid.
//   - count==0: target_found=0; bbox/target outputs = 0.
//   - 0<count<MIN_PIX: bbox published, target_found=0.
//  Centre arithmetic: sum in XW+1/YW+1 bits, then >>1 (floor); no overflow.
//  sof during ACCUM:
//   - frame_err pulse; no result_valid.
//   - Current frame discarded; a new frame restarts at that pixel.
//  sof coincident with final eol: the sof takes precedence, frame_err pulses.
//  busy = (state==ACCUM).
//  rst mid-frame: immediate return to reset state; held results are cleared.
// CONFIGURATION
//  TARGET_DIRECTION_EN defined: adds output steer_dir[1:0], registered with the results.
//   - 0 none (target_found=0).
//   - 1 left: target_x < IMG_W/2-DEADBAND.
//   - 2 right: target_x > IMG_W/2+DEADBAND.
//   - 3 centre: otherwise.
//  TARGET_DIRECTION_EN undefined: port and logic absent; all other behaviour identical.
// STRUCTURE
//  target_pkg:
//   - colour_e enum (ORANGE..GREEN).
//   - dir_e enum (DIR_NONE, DIR_LEFT, DIR_RIGHT, DIR_CENTRE).
//   - state_e (IDLE, ACCUM, REPORT).
//  Sub-module bbox_accumulator holds count/min/max registers.
//   - Inputs: clr, match, x, y.
//   - Outputs: count, min_x, max_x, min_y, max_y.
//  Top level holds the FSM, x/y counters, flag mux and result registers.
// TESTING
//  1. Frame with orange 10x10 block at x=100..109, y=50..59, sel=0
//     -> result_valid 1 cycle after last pixel; count=100, found=1, target_x=104, target_y=54.
//  2. Same frame, sel=3 (blue)
//     -> found=0, count=0, bbox/target all 0.
//  3. 40 matching pixels (<MIN_PIX) at x=0..39, y=0
//     -> found=0, count=40, bbox_min_x=0, bbox_max_x=39.
//  4. sof reasserted at line 120 of frame
//     -> frame_err pulse, no result_valid; next full frame reports normally.
//  5. Single match at (319,239) on the final pixel
//     -> count=1, bbox=(319,319,239,239), target=(319,239).
//  6. rst pulsed mid-frame -> all outputs 0, busy=0.
//     With TARGET_DIRECTION_EN, block at x=10..20 -> steer_dir=1.

Source files
------------

// File: rtl/target_locator_pkg.sv
// ----------------------------------------------------------------------------
// target_pkg
//   Shared types and default geometry for the target locator.
//   - colour_e : colour selector encoding (values above GREEN select nothing)
//   - dir_e    : steering hint published with the results
//   - state_e  : frame FSM states
//   - select_flag() : picks the selected colour flag out of the flag vector
// ----------------------------------------------------------------------------
package target_pkg;

    localparam int IMG_W_DEF    = 320;
    localparam int IMG_H_DEF    = 240;
    localparam int MIN_PIX_DEF  = 64;
    localparam int DEADBAND_DEF = 16;

    typedef enum logic [2:0] {
        ORANGE = 3'd0,
        PINK   = 3'd1,
        PURPLE = 3'd2,
        BLUE   = 3'd3,
        GREEN  = 3'd4
    } colour_e;

    typedef enum logic [1:0] {
        DIR_NONE   = 2'd0,
        DIR_LEFT   = 2'd1,
        DIR_RIGHT  = 2'd2,
        DIR_CENTRE = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_e;

    // flags = {green, blue, purple, pink, orange}; selectors 5-7 never match.
    function automatic logic select_flag(input logic [2:0] sel, input logic [4:0] flags);
        logic hit;
        hit = 1'b0;
        case (sel)
            ORANGE:  hit = flags[0];
            PINK:    hit = flags[1];
            PURPLE:  hit = flags[2];
            BLUE:    hit = flags[3];
            GREEN:   hit = flags[4];
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/target_locator_if.sv
// ----------------------------------------------------------------------------
// target_locator_if
//   Pixel stream in, per-frame results out.
//   Camera/threshold side (master drives): pix_valid, sof, eol, is_<colour>
//   flags, target_sel.
//   Locator side (slave drives): busy, result_valid, target_found, target_x/y,
//   bbox_min/max_x/y, pixel_count, frame_err, and steer_dir when
//   TARGET_DIRECTION_EN is defined.
// ----------------------------------------------------------------------------
interface target_locator_if import target_pkg::*; #(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W * IMG_H + 1);

    logic          pix_valid;
    logic          sof;
    logic          eol;
    logic          is_orange;
    logic          is_pink;
    logic          is_purple;
    logic          is_blue;
    logic          is_green;
    logic [2:0]    target_sel;

    logic          busy;
    logic          result_valid;
    logic          target_found;
    logic [XW-1:0] target_x;
    logic [YW-1:0] target_y;
    logic [XW-1:0] bbox_min_x;
    logic [XW-1:0] bbox_max_x;
    logic [YW-1:0] bbox_min_y;
    logic [YW-1:0] bbox_max_y;
    logic [CW-1:0] pixel_count;
    logic          frame_err;
`ifdef TARGET_DIRECTION_EN
    logic [1:0]    steer_dir;
`endif

    modport master (
        output pix_valid, sof, eol, is_orange, is_pink, is_purple, is_blue, is_green, target_sel,
        input  busy, result_valid, target_found, target_x, target_y,
               bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y, pixel_count, frame_err
`ifdef TARGET_DIRECTION_EN
        , input steer_dir
`endif
    );

    modport slave (
        input  pix_valid, sof, eol, is_orange, is_pink, is_purple, is_blue, is_green, target_sel,
        output busy, result_valid, target_found, target_x, target_y,
               bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y, pixel_count, frame_err
`ifdef TARGET_DIRECTION_EN
        , output steer_dir
`endif
    );

endinterface

// File: rtl/target_locator_bbox_accumulator.sv
// ----------------------------------------------------------------------------
// bbox_accumulator
//   Holds the per-frame matching-pixel count and bounding box.
//   Ports: clk, rst (async, active-high), clr_i (start a new frame),
//   match_i (current pixel matches), x_i/y_i (current pixel position),
//   count_o, min_x_o, max_x_o, min_y_o, max_y_o.
//   The outputs are a look-ahead view that already includes the current
//   pixel, so the top can capture final results on the same edge that
//   consumes the last pixel of the frame.
// ----------------------------------------------------------------------------
module bbox_accumulator #(
    parameter int XW = 9,
    parameter int YW = 8,
    parameter int CW = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          match_i,
    input  logic [XW-1:0] x_i,
    input  logic [YW-1:0] y_i,
    output logic [CW-1:0] count_o,
    output logic [XW-1:0] min_x_o,
    output logic [XW-1:0] max_x_o,
    output logic [YW-1:0] min_y_o,
    output logic [YW-1:0] max_y_o
);

    logic [CW-1:0] count_q, count_d;
    logic [XW-1:0] min_x_q, min_x_d, max_x_q, max_x_d;
    logic [YW-1:0] min_y_q, min_y_d, max_y_q, max_y_d;

    always_comb begin
        // NOTE: every combinational output gets a value before any branch, so no latch is inferred.
        // A clear starts from an empty box; the clearing pixel may still match.
        count_d = clr_i ? '0 : count_q;
        min_x_d = clr_i ? '0 : min_x_q;
        max_x_d = clr_i ? '0 : max_x_q;
        min_y_d = clr_i ? '0 : min_y_q;
        max_y_d = clr_i ? '0 : max_y_q;

        if (match_i) begin
            if (count_d == '0) begin
                // First match of the frame seeds both corners.
                min_x_d = x_i;
                max_x_d = x_i;
                min_y_d = y_i;
                max_y_d = y_i;
            end else begin
                if (x_i < min_x_d) min_x_d = x_i;
                if (x_i > max_x_d) max_x_d = x_i;
                if (y_i < min_y_d) min_y_d = y_i;
                if (y_i > max_y_d) max_y_d = y_i;
            end
            if (count_d != '1) count_d = count_d + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            min_x_q <= '0;
            max_x_q <= '0;
            min_y_q <= '0;
            max_y_q <= '0;
        end else begin
            count_q <= count_d;
            min_x_q <= min_x_d;
            max_x_q <= max_x_d;
            min_y_q <= min_y_d;
            max_y_q <= max_y_d;
        end
    end

    assign count_o = count_d;
    assign min_x_o = min_x_d;
    assign max_x_o = max_x_d;
    assign min_y_o = min_y_d;
    assign max_y_o = max_y_d;

endmodule

// File: rtl/target_locator.sv
// ----------------------------------------------------------------------------
// target_locator
//   Finds one selected colour in each camera frame and reports pixel count,
//   bounding box and centre at end of frame.
//   Ports: clk (pixel clock), rst (async, active-high), bus (slave side of
//   target_locator_if: pixel stream and flags in, results out).
//   Optional feature macro: TARGET_DIRECTION_EN adds steer_dir (left / right /
//   centre hint derived from target_x and DEADBAND).
//   Contents: frame FSM, x/y position counters, colour flag mux and result
//   registers; count/bbox accumulation lives in bbox_accumulator.
// ----------------------------------------------------------------------------
module target_locator import target_pkg::*; #(
    parameter int IMG_W    = IMG_W_DEF,
    parameter int IMG_H    = IMG_H_DEF,
    parameter int MIN_PIX  = MIN_PIX_DEF
`ifdef TARGET_DIRECTION_EN
    , parameter int DEADBAND = DEADBAND_DEF
`endif
) (
    input  logic           clk,
    input  logic           rst,
    target_locator_if.slave bus
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W * IMG_H + 1);

    state_e        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [2:0]    sel_q, sel_d;

    logic          found_q, found_d;
    logic [CW-1:0] res_count_q, res_count_d;
    logic [XW-1:0] res_min_x_q, res_min_x_d, res_max_x_q, res_max_x_d, res_cx_q, res_cx_d;
    logic [YW-1:0] res_min_y_q, res_min_y_d, res_max_y_q, res_max_y_d, res_cy_q, res_cy_d;
    logic          frame_err_q, frame_err_d;
`ifdef TARGET_DIRECTION_EN
    dir_e          steer_q, steer_d;
`endif

    logic          start;
    logic          acc_en;
    logic          finish;
    logic          match;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic [2:0]    cur_sel;

    logic [CW-1:0] acc_count;
    logic [XW-1:0] acc_min_x, acc_max_x;
    logic [YW-1:0] acc_min_y, acc_max_y;
    logic [XW:0]   sum_x;
    logic [YW:0]   sum_y;

    // A valid sof always starts a frame, whatever the state; it overrides a
    // coincident final eol, which is what turns that case into an abort.
    assign start   = bus.pix_valid & bus.sof;
    assign acc_en  = bus.pix_valid & (start | (state_q == ACCUM));
    assign finish  = (state_q == ACCUM) & bus.pix_valid & ~bus.sof & bus.eol
                   & (y_q == YW'(IMG_H - 1));

    // The sof pixel sits at (0,0) and uses the selector presented with it.
    assign cur_x   = start ? '0 : x_q;
    assign cur_y   = start ? '0 : y_q;
    assign cur_sel = start ? bus.target_sel : sel_q;
    assign match   = acc_en & select_flag(cur_sel, {bus.is_green, bus.is_blue, bus.is_purple,
                                                    bus.is_pink, bus.is_orange});

    bbox_accumulator #(.XW(XW), .YW(YW), .CW(CW)) u_acc (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (start),
        .match_i (match),
        .x_i     (cur_x),
        .y_i     (cur_y),
        .count_o (acc_count),
        .min_x_o (acc_min_x),
        .max_x_o (acc_max_x),
        .min_y_o (acc_min_y),
        .max_y_o (acc_max_y)
    );

    assign sum_x = {1'b0, acc_min_x} + {1'b0, acc_max_x};
    assign sum_y = {1'b0, acc_min_y} + {1'b0, acc_max_y};

    // Frame FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ACCUM;
            ACCUM:   if (finish) state_d = REPORT;
            REPORT:  state_d = start ? ACCUM : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Position counters and selector latch.
    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        sel_d = sel_q;
        if (acc_en) begin
            sel_d = cur_sel;
            if (bus.eol) begin
                x_d = '0;
                y_d = (cur_y == YW'(IMG_H - 1)) ? cur_y : cur_y + 1'b1;
            end else begin
                x_d = (cur_x == XW'(IMG_W - 1)) ? cur_x : cur_x + 1'b1;
                y_d = cur_y;
            end
        end
    end

    // Result capture on the edge that consumes the final pixel.
    always_comb begin
        found_d     = found_q;
        res_count_d = res_count_q;
        res_min_x_d = res_min_x_q;
        res_max_x_d = res_max_x_q;
        res_min_y_d = res_min_y_q;
        res_max_y_d = res_max_y_q;
        res_cx_d    = res_cx_q;
        res_cy_d    = res_cy_q;
        frame_err_d = (state_q == ACCUM) & start;
`ifdef TARGET_DIRECTION_EN
        steer_d     = steer_q;
`endif
        if (finish) begin
            res_count_d = acc_count;
            found_d     = (acc_count >= CW'(MIN_PIX));
            if (acc_count == '0) begin
                // Empty frame: publish an all-zero box rather than stale corners.
                res_min_x_d = '0;
                res_max_x_d = '0;
                res_min_y_d = '0;
                res_max_y_d = '0;
                res_cx_d    = '0;
                res_cy_d    = '0;
            end else begin
                res_min_x_d = acc_min_x;
                res_max_x_d = acc_max_x;
                res_min_y_d = acc_min_y;
                res_max_y_d = acc_max_y;
                res_cx_d    = sum_x[XW:1];
                res_cy_d    = sum_y[YW:1];
            end
`ifdef TARGET_DIRECTION_EN
            if (!found_d)
                steer_d = DIR_NONE;
            else if (res_cx_d < XW'(IMG_W / 2 - DEADBAND))
                steer_d = DIR_LEFT;
            else if (res_cx_d > XW'(IMG_W / 2 + DEADBAND))
                steer_d = DIR_RIGHT;
            else
                steer_d = DIR_CENTRE;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            sel_q       <= '0;
            found_q     <= 1'b0;
            res_count_q <= '0;
            res_min_x_q <= '0;
            res_max_x_q <= '0;
            res_min_y_q <= '0;
            res_max_y_q <= '0;
            res_cx_q    <= '0;
            res_cy_q    <= '0;
            frame_err_q <= 1'b0;
`ifdef TARGET_DIRECTION_EN
            steer_q     <= DIR_NONE;
`endif
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            sel_q       <= sel_d;
            found_q     <= found_d;
            res_count_q <= res_count_d;
            res_min_x_q <= res_min_x_d;
            res_max_x_q <= res_max_x_d;
            res_min_y_q <= res_min_y_d;
            res_max_y_q <= res_max_y_d;
            res_cx_q    <= res_cx_d;
            res_cy_q    <= res_cy_d;
            frame_err_q <= frame_err_d;
`ifdef TARGET_DIRECTION_EN
            steer_q     <= steer_d;
`endif
        end
    end

    assign bus.busy         = (state_q == ACCUM);
    assign bus.result_valid = (state_q == REPORT);
    assign bus.frame_err    = frame_err_q;
    assign bus.target_found = found_q;
    assign bus.pixel_count  = res_count_q;
    assign bus.bbox_min_x   = res_min_x_q;
    assign bus.bbox_max_x   = res_max_x_q;
    assign bus.bbox_min_y   = res_min_y_q;
    assign bus.bbox_max_y   = res_max_y_q;
    assign bus.target_x     = res_cx_q;
    assign bus.target_y     = res_cy_q;
`ifdef TARGET_DIRECTION_EN
    assign bus.steer_dir    = steer_q;
`endif

endmodule

// File: tb/tb_target_locator.sv
// ----------------------------------------------------------------------------
// tb_target_locator
//   Frame-level bench for target_locator. Each table row describes one frame
//   (a rectangular block of one colour flag plus the selector) and the result
//   it must produce. Lines outside the block are shortened to a single pixel
//   with eol so a full 240-line frame stays short. Expected events (result or
//   frame error) are queued as frames are sent and popped when the DUT pulses.
// ----------------------------------------------------------------------------
module tb_target_locator;

    localparam int IMG_W = 320;
    localparam int IMG_H = 240;
    localparam int NV    = 12;

    typedef struct {
        int colour;      // flag index set inside the block, 0..4
        int sel;         // target_sel at sof
        int sel_mid;     // target_sel after the sof pixel, -1 keeps sel
        int x0, x1, y0, y1;
        int abort_line;  // stop sending at this line, -1 for a full frame
        int end_sof;     // raise sof on the final pixel
        int e_count, e_found;
        int e_minx, e_maxx, e_miny, e_maxy;
        int e_tx, e_ty, e_dir;
    } vec_t;

    typedef struct {
        bit   is_err;
        int   row;
        vec_t v;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    target_locator_if bus ();

    target_locator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    vec_t vecs [NV];
    ev_t  exp_q [$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   in_frame = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},   32'(bus.busy), 0);
        check({tag, "_rv"},     32'(bus.result_valid), 0);
        check({tag, "_ferr"},   32'(bus.frame_err), 0);
        check({tag, "_found"},  32'(bus.target_found), 0);
        check({tag, "_count"},  32'(bus.pixel_count), 0);
        check({tag, "_tx"},     32'(bus.target_x), 0);
        check({tag, "_ty"},     32'(bus.target_y), 0);
        check({tag, "_minx"},   32'(bus.bbox_min_x), 0);
        check({tag, "_maxx"},   32'(bus.bbox_max_x), 0);
        check({tag, "_miny"},   32'(bus.bbox_min_y), 0);
        check({tag, "_maxy"},   32'(bus.bbox_max_y), 0);
`ifdef TARGET_DIRECTION_EN
        check({tag, "_dir"},    32'(bus.steer_dir), 0);
`endif
    endtask

    task automatic drive_pixel(input bit s, input bit e, input logic [4:0] f, input logic [2:0] sel);
        @(negedge clk);
        bus.pix_valid  = 1'b1;
        bus.sof        = s;
        bus.eol        = e;
        bus.target_sel = sel;
        {bus.is_green, bus.is_blue, bus.is_purple, bus.is_pink, bus.is_orange} = f;
    endtask

    task automatic drive_idle();
        @(negedge clk);
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        bus.eol       = 1'b0;
        {bus.is_green, bus.is_blue, bus.is_purple, bus.is_pink, bus.is_orange} = 5'b0;
    endtask

    task automatic send_frame(input int row, input vec_t v);
        ev_t ev;
        ev.row = row;
        ev.v   = v;
        if (in_frame) begin
            ev.is_err = 1'b1;
            exp_q.push_back(ev);
        end
        for (int y = 0; y < IMG_H; y++) begin
            int len;
            if (v.abort_line == y) begin
                in_frame = 1'b1;
                return;
            end
            len = (y >= v.y0 && y <= v.y1) ? v.x1 + 1 : 1;
            for (int x = 0; x < len; x++) begin
                bit          first, last;
                logic [4:0]  f;
                logic [2:0]  s;
                first = (x == 0 && y == 0);
                last  = (x == len - 1) && (y == IMG_H - 1);
                f     = (x >= v.x0 && x <= v.x1 && y >= v.y0 && y <= v.y1) ? 5'(1 << v.colour) : 5'b0;
                s     = (!first && v.sel_mid >= 0) ? 3'(v.sel_mid) : 3'(v.sel);
                drive_pixel(first || (last && v.end_sof != 0), x == len - 1, f, s);
            end
        end
        ev.is_err = (v.end_sof != 0);
        exp_q.push_back(ev);
        in_frame = (v.end_sof != 0);
        drive_idle();
    endtask

    // Scoreboard: every result_valid / frame_err pulse consumes one expectation.
    always @(negedge clk) begin
        if (!rst && (bus.result_valid || bus.frame_err)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_event: actual rv=%0d ferr=%0d required no event",
                         bus.result_valid, bus.frame_err);
            end else begin
                ev_t ev;
                ev = exp_q.pop_front();
                check($sformatf("row%0d_event{ferr,rv}", ev.row), 32'({bus.frame_err, bus.result_valid}),
                      ev.is_err ? 32'd2 : 32'd1);
                if (!ev.is_err) begin
                    check($sformatf("row%0d_count", ev.row), 32'(bus.pixel_count),  ev.v.e_count);
                    check($sformatf("row%0d_found", ev.row), 32'(bus.target_found), ev.v.e_found);
                    check($sformatf("row%0d_minx",  ev.row), 32'(bus.bbox_min_x),   ev.v.e_minx);
                    check($sformatf("row%0d_maxx",  ev.row), 32'(bus.bbox_max_x),   ev.v.e_maxx);
                    check($sformatf("row%0d_miny",  ev.row), 32'(bus.bbox_min_y),   ev.v.e_miny);
                    check($sformatf("row%0d_maxy",  ev.row), 32'(bus.bbox_max_y),   ev.v.e_maxy);
                    check($sformatf("row%0d_tx",    ev.row), 32'(bus.target_x),     ev.v.e_tx);
                    check($sformatf("row%0d_ty",    ev.row), 32'(bus.target_y),     ev.v.e_ty);
`ifdef TARGET_DIRECTION_EN
                    check($sformatf("row%0d_dir",   ev.row), 32'(bus.steer_dir),    ev.v.e_dir);
`endif
                end
            end
        end
    end

    initial begin
        //         col sel mid  x0   x1   y0   y1  abort es  cnt fnd minx maxx miny maxy  tx   ty dir
        vecs[0]  = '{0,  0, -1, 100, 109,  50,  59,  -1, 0, 100, 1, 100, 109,  50,  59, 104,  54, 1};
        vecs[1]  = '{0,  3, -1, 100, 109,  50,  59,  -1, 0,   0, 0,   0,   0,   0,   0,   0,   0, 0};
        vecs[2]  = '{0,  0, -1,   0,  39,   0,   0,  -1, 0,  40, 0,   0,  39,   0,   0,  19,   0, 0};
        vecs[3]  = '{0,  0, -1, 100, 109,  50,  59, 120, 0,   0, 0,   0,   0,   0,   0,   0,   0, 0};
        vecs[4]  = '{1,  1, -1, 200, 215, 100, 103,  -1, 0,  64, 1, 200, 215, 100, 103, 207, 101, 2};
        vecs[5]  = '{2,  2, -1, 319, 319, 239, 239,  -1, 0,   1, 0, 319, 319, 239, 239, 319, 239, 0};
        vecs[6]  = '{4,  4, -1, 140, 179,   0,   1,  -1, 0,  80, 1, 140, 179,   0,   1, 159,   0, 3};
        vecs[7]  = '{3,  5, -1,   0,   9,   0,   9,  -1, 0,   0, 0,   0,   0,   0,   0,   0,   0, 0};
        vecs[8]  = '{3,  3, -1,   0,  62,  10,  10,  -1, 0,  63, 0,   0,  62,  10,  10,  31,  10, 0};
        vecs[9]  = '{0,  0,  3, 100, 109,  50,  59,  -1, 0, 100, 1, 100, 109,  50,  59, 104,  54, 1};
        vecs[10] = '{0,  0, -1, 100, 109,  50,  59,  -1, 1,   0, 0,   0,   0,   0,   0,   0,   0, 0};
        vecs[11] = '{0,  0, -1,  10,  20,   5,  20,  -1, 0, 176, 1,  10,  20,   5,  20,  15,  12, 1};

        bus.pix_valid  = 1'b0;
        bus.sof        = 1'b0;
        bus.eol        = 1'b0;
        bus.target_sel = 3'd0;
        {bus.is_green, bus.is_blue, bus.is_purple, bus.is_pink, bus.is_orange} = 5'b0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        for (int i = 0; i < NV; i++) begin
            send_frame(i, vecs[i]);
            if (i == 0) begin
                // send_frame returned on the negedge after the final pixel: REPORT now.
                check("row0_rv_latency", 32'(bus.result_valid), 1);
                check("row0_busy_in_report", 32'(bus.busy), 0);
                @(negedge clk);
                check("row0_rv_one_cycle", 32'(bus.result_valid), 0);
                repeat (3) @(negedge clk);
                check("row0_hold_tx", 32'(bus.target_x), vecs[0].e_tx);
                check("row0_hold_count", 32'(bus.pixel_count), vecs[0].e_count);
            end
        end
        repeat (3) @(negedge clk);

        // Reset in the middle of a frame, with non-zero results being held.
        begin
            vec_t r;
            r = vecs[0];
            r.abort_line = 60;
            send_frame(100, r);
            drive_idle();
            check("midframe_busy", 32'(bus.busy), 1);
            rst = 1'b1;
            #1;
            check_all_zero("midrst");
            in_frame = 1'b0;
            @(negedge clk);
            rst = 1'b0;
        end

        // Recovery after reset: a clean frame reports normally with no frame_err.
        send_frame(0, vecs[0]);

        for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: actual %0d pending events required 0", exp_q.size());
        end
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
